// File: rtl/des_key_scheduler.sv
// des_key_scheduler: splits a 56-bit DES key range into 2^CHUNK_LOG2-key
// chunks and hands them round-robin to NUM_CORES cracker cores.
//
// Ports:
//   ACLK, ARESETN         clock, async active-low reset
//   cfg_start/cfg_abort   start / stop-dispatch pulses
//   cfg_key_first/last    inclusive search range
//   core_go/core_base     one-hot dispatch strobe and chunk base key
//   core_done/hit/hit_key per-core completion, match flag, match key
//   busy/done/found       search status
//   found_key             first latched matching key
//   chunks_issued         dispatches in the current search (saturating)
module des_key_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int CHUNK_LOG2 = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cfg_start,
  input  logic                    cfg_abort,
  input  logic [55:0]             cfg_key_first,
  input  logic [55:0]             cfg_key_last,
  output logic [NUM_CORES-1:0]    core_go,
  output logic [55:0]             core_base,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES-1:0]    core_hit,
  input  logic [NUM_CORES*56-1:0] core_hit_key,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [55:0]             found_key,
  output logic [31:0]             chunks_issued
);

  localparam int RPW = $clog2(NUM_CORES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [55:0]          last_q;
  logic [55:0]          next_base_q;
  logic [NUM_CORES-1:0] outstanding_q;
  logic [RPW-1:0]       rp_q;

  logic                 start_ok;
  logic [NUM_CORES-1:0] hit_vec;
  logic                 hit_any;
  logic                 hit_new;
  logic [55:0]          hit_key;
  logic [56:0]          base_sum;
  logic                 range_end;
  logic                 gnt_vld;
  logic [RPW-1:0]       gnt_idx;
  logic [NUM_CORES-1:0] gnt_oh;
  logic                 dispatch;
  logic [RPW-1:0]       rp_d;

  assign start_ok = cfg_start &&
    (state_q == S_IDLE || state_q == S_DONE);

  // Only cores that actually hold a chunk may report.
  assign hit_vec = core_done & core_hit & outstanding_q;
  assign hit_any = |hit_vec;
  assign hit_new = hit_any && !found;

  // 57-bit add so a carry out of bit 55 ends the range
  assign base_sum = {1'b0, next_base_q} +
    (57'd1 << CHUNK_LOG2);
  assign range_end = base_sum[56] ||
    (base_sum[55:0] > last_q);

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == S_IDLE),
      (state_q == S_DONE): begin
        if (start_ok) begin
          if (cfg_key_first > cfg_key_last)
            state_d = S_DRAIN;
          else
            state_d = S_DISPATCH;
        end
      end
      (state_q == S_DISPATCH): begin
        if (cfg_abort || hit_any)
          state_d = S_DRAIN;
        else if (dispatch && range_end)
          state_d = S_DRAIN;
      end
      (state_q == S_DRAIN): begin
        if (outstanding_q == '0)
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/decision logic: round-robin grant and hit select
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!gnt_vld &&
          !outstanding_q[(int'(rp_q) + i) % NUM_CORES]) begin
        gnt_vld = 1'b1;
        gnt_idx = RPW'((int'(rp_q) + i) % NUM_CORES);
      end
    end
    gnt_oh = NUM_CORES'(1) << gnt_idx;
    dispatch = (state_q == S_DISPATCH) &&
      !cfg_abort && !hit_any && gnt_vld;
    rp_d = (gnt_idx == RPW'(NUM_CORES - 1)) ?
      '0 : gnt_idx + 1'b1;
    // Scan downward so the lowest index wins.
    hit_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit_vec[i])
        hit_key = core_hit_key[i*56 +: 56];
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      core_go       <= '0;
      core_base     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      found_key     <= '0;
      chunks_issued <= '0;
      last_q        <= '0;
      next_base_q   <= '0;
      outstanding_q <= '0;
      rp_q          <= '0;
    end else begin
      core_go <= dispatch ? gnt_oh : '0;
      busy    <= (state_d == S_DISPATCH) ||
                 (state_d == S_DRAIN);
      done    <= (state_d == S_DONE);
      outstanding_q <= (outstanding_q & ~core_done) |
        (dispatch ? gnt_oh : '0);
      if (start_ok) begin
        last_q        <= cfg_key_last;
        next_base_q   <= cfg_key_first;
        found         <= 1'b0;
        found_key     <= '0;
        chunks_issued <= '0;
      end else begin
        if (dispatch) begin
          core_base   <= next_base_q;
          next_base_q <= base_sum[55:0];
          rp_q        <= rp_d;
          if (chunks_issued != 32'hFFFF_FFFF)
            chunks_issued <= chunks_issued + 32'd1;
        end
        if (hit_new) begin
          found     <= 1'b1;
          found_key <= hit_key;
        end
      end
    end
  end

endmodule

// File: doc/des_key_scheduler.md
DES_KEY_SCHEDULER -- requirements
Module: des_key_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of DES cracker cores served (2..16).
REQ-002 SHALL have parameter CHUNK_LOG2, default 16: log2 of keys per dispatched chunk (1..32).
REQ-003 SHALL have port ACLK input 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port ARESETN input 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port cfg_start input 1: single-cycle pulse that starts a search.
REQ-006 SHALL have port cfg_abort input 1: single-cycle pulse that stops dispatching.
REQ-007 SHALL have port cfg_key_first input 56: first key of the search range.
REQ-008 SHALL have port cfg_key_last input 56: last key of the search range, inclusive.
REQ-009 SHALL have port core_go output NUM_CORES: one-hot, one-cycle chunk dispatch strobe.
REQ-010 SHALL have port core_base output 56: chunk base key, valid while core_go is nonzero.
REQ-011 SHALL have port core_done input NUM_CORES: one-cycle pulse per core when its chunk is finished.
REQ-012 SHALL have port core_hit input NUM_CORES: qualified by core_done; the chunk contained a match.
REQ-013 SHALL have port core_hit_key input NUM_CORES*56: matching key, core i at bits [56i+55:56i].
REQ-014 SHALL have port busy output 1: a search is in progress.
REQ-015 SHALL have port done output 1: search finished, sticky until the next accepted start.
REQ-016 SHALL have port found output 1: a match was latched.
REQ-017 SHALL have port found_key output 56: the latched matching key.
REQ-018 SHALL have port chunks_issued output 32: count of dispatches in the current search.

Function
REQ-019 SHALL implement FSM states IDLE, DISPATCH, DRAIN, DONE.
REQ-020 SHALL accept cfg_start only in IDLE or DONE; it is ignored in DISPATCH and DRAIN.
REQ-021 SHALL on accepted start latch first/last and set next_base=cfg_key_first.
REQ-022 SHALL on accepted start clear done, found, found_key and chunks_issued, set busy and enter DISPATCH.
REQ-023 SHALL, if cfg_key_first > cfg_key_last on start, go to DRAIN with no dispatch.
REQ-024 SHALL keep an outstanding bitmask; core i is eligible when its bit is 0.
REQ-025 SHALL issue at most one dispatch per cycle, and none in the cycle start is sampled.
REQ-026 SHALL make the first core_go appear the cycle after start is sampled; outputs are registered.
REQ-027 SHALL pick the dispatched core round-robin: search from pointer rp.
REQ-028 SHALL on a grant to core g set rp=(g+1) mod NUM_CORES; rp=0 after reset.
REQ-029 SHALL on dispatch drive core_base=next_base and set the outstanding bit.
REQ-030 SHALL on dispatch increment chunks_issued and advance next_base by 2^CHUNK_LOG2 (57-bit add).
REQ-031 SHALL move DISPATCH to DRAIN when the next next_base > last or the add carries out of bit 55; no wrap-around.
REQ-032 SHALL on core_done[i] clear outstanding bit i; that core is eligible from the next cycle, never the same cycle.
REQ-033 SHALL, when core_done & core_hit is nonzero and found=0, latch the lowest-index hit key and set found.
REQ-034 SHALL stop dispatching and move DISPATCH to DRAIN on a hit.
REQ-035 SHALL ignore later hits once found=1; hits arriving in DRAIN are still latched if found=0.
REQ-036 SHALL on cfg_abort in DISPATCH move to DRAIN; no further core_go; found unaffected.
REQ-037 SHALL in DRAIN wait for outstanding==0, then enter DONE.
REQ-038 SHALL in DONE hold done=1 and busy=0; busy=1 exactly in DISPATCH and DRAIN.
REQ-039 SHALL ignore core_done for a core whose outstanding bit is 0.
REQ-040 SHALL saturate chunks_issued at 0xFFFFFFFF.

Reset
REQ-041 SHALL on ARESETN=0, immediately and asynchronously, zero core_go, core_base, busy, done, found, found_key and chunks_issued.
REQ-042 SHALL on ARESETN=0 clear outstanding, set rp=0 and state=IDLE, including mid-search.
REQ-043 SHALL release reset synchronously with ACLK; no dispatch until a new cfg_start.

Verification (NUM_CORES=4, CHUNK_LOG2=4)
REQ-044 SHALL test: first=0x0, last=0x3F, start, cores answer done without hit -> core_go 0001,0010,0100,1000 on 4 consecutive cycles, bases 0x00,0x10,0x20,0x30; done=1, chunks_issued=4, found=0.
REQ-045 SHALL test: range 0x0..0xFF, core 2 done+hit key 0x25 -> found=1, found_key=0x25, no core_go afterwards, done only after remaining outstanding cores pulse done.
REQ-046 SHALL test: cores 1 and 3 done+hit same cycle, keys 0x1A and 0x3B -> found_key=0x1A; later hit from core 0 ignored.
REQ-047 SHALL test: first=0xFFFFFFFFFFFFF0, last=0xFFFFFFFFFFFFFF -> exactly one core_go, base 0xFFFFFFFFFFFFF0, no wrap; chunks_issued=1.
REQ-048 SHALL test: first=0x40, last=0x3F -> no core_go; done=1 two cycles after start; chunks_issued=0.
REQ-049 SHALL test: abort after 2 dispatches -> chunks_issued=2, done after both done pulses; and ARESETN low mid-search -> all outputs 0 the same instant.
